// File: rtl/usb_serial_ep_fifo.sv
// usb_serial_ep_fifo: byte-stream bridge between a USB bulk OUT/IN endpoint
// pair and a valid/ready fabric client.
// - RX path: host OUT bytes are buffered and presented on rx_*. When the RX
//   FIFO cannot take another byte, the host is held off and no byte is lost.
//   SETUP bytes are read and thrown away.
// - TX path: fabric bytes are buffered and sent as IN packets of at most
//   MAX_PKT bytes. A packet of exactly MAX_PKT bytes that empties the FIFO is
//   followed by a zero-length packet.
// Optional feature macro: USB_SERIAL_FLUSH_TIMER_EN. When it is defined, a
// short packet is sent only after FLUSH_CYCLES idle cycles. When it is not
// defined, a short packet starts as soon as data is waiting.
module usb_serial_ep_fifo #(
  parameter int RX_AW        = 6,
  parameter int TX_AW        = 6,
  parameter int MAX_PKT      = 64,
  parameter int FLUSH_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       out_ep_req,
  input  logic       out_ep_grant,
  input  logic       out_ep_data_avail,
  input  logic       out_ep_setup,
  output logic       out_ep_data_get,
  input  logic [7:0] out_ep_data,
  output logic       out_ep_stall,
  input  logic       out_ep_acked,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int RX_D = 1 << RX_AW;
  localparam int TX_D = 1 << TX_AW;
  localparam int PW   = $clog2(MAX_PKT + 1);

  localparam logic [RX_AW:0] RX_DEPTH = RX_D[RX_AW:0];
  localparam logic [RX_AW:0] RX_TWO   = 2;
  localparam logic [TX_AW:0] TX_DEPTH = TX_D[TX_AW:0];
  localparam logic [TX_AW:0] TX_MAXC  = MAX_PKT[TX_AW:0];
  localparam logic [PW-1:0]  PKT_MAX  = MAX_PKT[PW-1:0];

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  // ---------------------------------------------------------------- RX path
  logic [7:0]       rx_mem [RX_D];
  logic [RX_AW-1:0] rx_wp_q, rx_rp_q;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d, rx_free;
  logic             get_q, rx_wr, rx_rd;

  // Free slots are counted net of the byte already in flight from last
  // cycle's get. Two are kept spare, so get drops before the FIFO fills.
  assign rx_free         = RX_DEPTH - rx_cnt_q - {{RX_AW{1'b0}}, get_q};
  assign out_ep_req      = out_ep_data_avail;
  assign out_ep_data_get = out_ep_grant && out_ep_data_avail && (rx_free >= RX_TWO);
  assign rx_wr           = get_q && !out_ep_setup && (rx_cnt_q != RX_DEPTH);
  assign rx_valid        = (rx_cnt_q != '0);
  assign rx_rd           = rx_valid && rx_ready;
  assign rx_data         = rx_valid ? rx_mem[rx_rp_q] : 8'h00;

  // RX occupancy next-state
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    case ({rx_wr, rx_rd})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // RX storage write; the byte arrives the cycle after its get
  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp_q] <= out_ep_data;
  end

  // RX pointers, count and in-flight flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      get_q    <= 1'b0;
    end else begin
      get_q    <= out_ep_data_get;
      rx_cnt_q <= rx_cnt_d;
      if (rx_wr) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_rd) rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX path
  logic [7:0]       tx_mem [TX_D];
  logic [TX_AW-1:0] tx_wp_q, tx_rp_q;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic             rdy_q, tx_wr, tx_rd, tx_empty;
  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    pkt_q, pkt_d;
  logic             zlp_q, zlp_d, flush;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_ready = rdy_q && (tx_cnt_q != TX_DEPTH);
  assign tx_wr    = tx_valid && tx_ready;
  assign tx_rd    = in_ep_data_put;

  assign in_ep_data_put  = (state_q == S_FILL) && in_ep_data_free && !tx_empty && (pkt_q < PKT_MAX);
  assign in_ep_data      = in_ep_data_put ? tx_mem[tx_rp_q] : 8'h00;
  assign in_ep_req       = (state_q == S_REQ) || (state_q == S_FILL) || (state_q == S_DONE);
  assign in_ep_data_done = (state_q == S_DONE);
  assign out_ep_stall    = 1'b0;
  assign in_ep_stall     = 1'b0;

`ifdef USB_SERIAL_FLUSH_TIMER_EN
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LIM = FLUSH_CYCLES[FW-1:0];
  logic [FW-1:0] idle_q;

  // Idle timer: counts quiet IDLE cycles and saturates at the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          idle_q <= '0;
    else if (tx_wr || state_q != S_IDLE)   idle_q <= '0;
    else if (idle_q != FLUSH_LIM)          idle_q <= idle_q + 1'b1;
  end
  assign flush = (idle_q == FLUSH_LIM);
`else
  localparam int unused_flush_cycles = FLUSH_CYCLES;
  assign flush = 1'b1;
`endif

  logic unused_ok;
  assign unused_ok = out_ep_acked;

  // TX occupancy next-state
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_wr, tx_rd})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // IN packetiser: pick when to send, fill the buffer, hand it over, wait for ACK
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    zlp_d   = zlp_q;
    case (state_q)
      S_IDLE: begin
        pkt_d = '0;
        if (tx_cnt_q >= TX_MAXC || ((!tx_empty || zlp_q) && flush)) begin
          state_d = S_REQ;
          zlp_d   = 1'b0;   // any packet sent now ends the transfer
        end
      end
      S_REQ:  if (in_ep_grant) state_d = S_FILL;
      S_FILL: begin
        if (in_ep_data_put) pkt_d = pkt_q + 1'b1;
        if (pkt_q == PKT_MAX || tx_empty) begin
          state_d = S_DONE;
          if (pkt_q == PKT_MAX && tx_empty) zlp_d = 1'b1;
        end
      end
      S_DONE: state_d = S_WAIT;
      S_WAIT: if (in_ep_acked) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // TX storage write
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp_q] <= tx_data;
  end

  // TX pointers, count, FSM state and ready enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rdy_q    <= 1'b0;
      state_q  <= S_IDLE;
      pkt_q    <= '0;
      zlp_q    <= 1'b0;
    end else begin
      rdy_q    <= 1'b1;
      tx_cnt_q <= tx_cnt_d;
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      zlp_q    <= zlp_d;
      if (tx_wr) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_rd) tx_rp_q <= tx_rp_q + 1'b1;
    end
  end

endmodule
